// File: rtl/mdu_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
// The pipeline drives the master side and the MDU implements the slave side.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srcA, srcB, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and mthi/mtlo moves.
// Operands are captured at issue, and the result is committed in a single edge after a fixed latency.
module mdu #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] W_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [2*WIDTH-1:0]      sprod_s;
  logic [2*WIDTH-1:0]      uprod_s;
  logic signed [WIDTH-1:0] sa_s, sb_s, sq_s, sr_s;
  logic [WIDTH-1:0]        uq_s, ur_s;
  logic [WIDTH-1:0]        res_hi_s, res_lo_s;

  // Arithmetic on the captured operands; only sampled at the completion edge.
  assign sprod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign uprod_s = {W_ZERO, a_q} * {W_ZERO, b_q};
  assign sa_s    = $signed(a_q);
  assign sb_s    = $signed(b_q);
  assign sq_s    = sa_s / sb_s;
  assign sr_s    = sa_s % sb_s;
  assign uq_s    = a_q / b_q;
  assign ur_s    = a_q % b_q;

  // Result selection including the divide-by-zero and signed-overflow corner cases.
  always_comb begin
    res_hi_s = hi_q;
    res_lo_s = lo_q;
    case (op_q)
      OP_MULT:  {res_hi_s, res_lo_s} = sprod_s;
      OP_MULTU: {res_hi_s, res_lo_s} = uprod_s;
      OP_DIV: begin
        if (b_q == W_ZERO) begin
          res_lo_s = W_ONES;
          res_hi_s = a_q;
        end else if ((a_q == W_MIN) && (b_q == W_ONES)) begin
          res_lo_s = W_MIN;
          res_hi_s = W_ZERO;
        end else begin
          res_lo_s = sq_s;
          res_hi_s = sr_s;
        end
      end
      OP_DIVU: begin
        if (b_q == W_ZERO) begin
          res_lo_s = W_ONES;
          res_hi_s = a_q;
        end else begin
          res_lo_s = uq_s;
          res_hi_s = ur_s;
        end
      end
      default: begin
        res_hi_s = hi_q;
        res_lo_s = lo_q;
      end
    endcase
  end

  // Next-state logic: issue in IDLE; count down, cancel or commit in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              state_d = S_BUSY;
              cnt_d   = MULT_LOAD;
              op_d    = bus.op;
              a_d     = bus.srcA;
              b_d     = bus.srcB;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_BUSY;
              cnt_d   = DIV_LOAD;
              op_d    = bus.op;
              a_d     = bus.srcA;
              b_d     = bus.srcB;
            end
            OP_MTHI: hi_d = bus.srcA;
            OP_MTLO: lo_d = bus.srcA;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = S_IDLE;
          hi_d    = res_hi_s;
          lo_d    = res_lo_s;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, operand and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      op_q    <= 3'd0;
      a_q     <= W_ZERO;
      b_q     <= W_ZERO;
      hi_q    <= W_ZERO;
      lo_q    <= W_ZERO;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == S_BUSY);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
